// File: rtl/cm7sys_tcmreq.sv
// cm7sys_tcmreq: request-side posting stage between the CM7 TCM master port
// and the TCM macro wrapper. Posts core writes into a small FIFO, drains them
// in order ahead of any read, returns read data and latches write errors.
// Optional feature: define CM7TCMREQ_RAWFWD_EN to forward reads that hit a
// full-word write still sitting in the FIFO.
module cm7sys_tcmreq #(
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    // core side
    input  logic            c_cs,
    input  logic [DW/8-1:0] c_we,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wd,
    output logic            c_stall,
    output logic [DW-1:0]   c_rd,
    output logic            c_rvalid,
    output logic            c_rerr,
    // TCM side
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   wd_o,
    output logic            cs_o,
    output logic [DW/8-1:0] we_o,
    input  logic [DW-1:0]   rd_i,
    input  logic            wait_i,
    input  logic            err_i,
    // write-error status
    output logic            werr,
    output logic [AW-1:0]   werr_addr,
    input  logic            werr_clr
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    // FIFO storage and pointers
    logic [AW-1:0] r_fa [DEPTH];
    logic [BW-1:0] r_fb [DEPTH];
    logic [DW-1:0] r_fd [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;

    // in-flight and response state
    logic          r_wif;
    logic [AW-1:0] r_wif_addr;
    logic          r_rvalid;
    logic          r_fwd;
    logic [DW-1:0] r_fwd_data;
    logic          r_werr;
    logic [AW-1:0] r_werr_addr;

    logic          w_empty;
    logic          w_full;
    logic [IW-1:0] w_ridx;
    logic [IW-1:0] w_widx;
    logic          w_is_wr;
    logic          w_core_wr;
    logic          w_core_rd;
    logic          w_rd_go;
    logic          w_head_own;
    logic          w_tcm_acc;
    logic          w_pop;
    logic          w_push;
    logic          w_rd_acc;
    logic          w_fwd;
    logic [DW-1:0] w_fwd_data;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign w_ridx  = r_rptr[IW-1:0];
    assign w_widx  = r_wptr[IW-1:0];

    // Core request decode; reset blocks any combinational read pass-through.
    assign w_is_wr   = |c_we;
    assign w_core_wr = c_cs & w_is_wr & ~reset;
    assign w_core_rd = c_cs & ~w_is_wr & ~reset;

`ifdef CM7TCMREQ_RAWFWD_EN
    logic          w_hit;
    logic          w_hit_full;
    logic [DW-1:0] w_hit_data;
    logic [PW-1:0] w_cnt;
    logic [PW-1:0] w_kptr;

    // Scan valid entries oldest to newest so the newest address match wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_full = 1'b0;
        w_hit_data = '0;
        w_cnt      = r_wptr - r_rptr;
        w_kptr     = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_kptr = r_rptr + PW'(k);
            if ((PW'(k) < w_cnt) && (r_fa[w_kptr[IW-1:0]] == c_addr)) begin
                w_hit      = 1'b1;
                w_hit_full = &r_fb[w_kptr[IW-1:0]];
                w_hit_data = r_fd[w_kptr[IW-1:0]];
            end
        end
    end

    assign w_fwd      = w_core_rd & ~w_empty & w_hit & w_hit_full;
    assign w_fwd_data = w_hit_data;
`else
    assign w_fwd      = 1'b0;
    assign w_fwd_data = '0;
`endif

    // TCM port ownership: FIFO head, else a core read, else idle.
    assign w_head_own = ~w_empty;
    assign w_rd_go    = w_core_rd & w_empty & ~r_wif;
    assign cs_o       = w_head_own | w_rd_go;
    assign addr_o     = w_head_own ? r_fa[w_ridx] : (w_rd_go ? c_addr : '0);
    assign wd_o       = w_head_own ? r_fd[w_ridx] : '0;
    assign we_o       = w_head_own ? r_fb[w_ridx] : '0;

    assign w_tcm_acc = cs_o & ~wait_i;
    assign w_pop     = w_head_own & w_tcm_acc;
    assign w_rd_acc  = w_rd_go & ~wait_i;
    assign w_push    = w_core_wr & ~w_full;

    // Writes stall only on a full FIFO; reads stall on pending writes or TCM wait.
    always_comb begin
        c_stall = 1'b0;
        if (w_core_wr) begin
            c_stall = w_full;
        end else if (w_core_rd) begin
            c_stall = ~w_fwd & (~w_empty | r_wif | wait_i);
        end
    end

    // Read response: TCM data in the cycle after accept, or the forwarded word.
    assign c_rvalid  = r_rvalid;
    assign c_rd      = r_rvalid ? (r_fwd ? r_fwd_data : rd_i) : '0;
    assign c_rerr    = r_rvalid & ~r_fwd & err_i;
    assign werr      = r_werr;
    assign werr_addr = r_werr_addr;

    // FIFO payload storage (no reset needed, guarded by pointers).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fa[w_widx] <= c_addr;
            r_fb[w_widx] <= c_we;
            r_fd[w_widx] <= c_wd;
        end
    end

    // FIFO pointers, in-flight tracking and read response state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wif      <= 1'b0;
            r_wif_addr <= '0;
            r_rvalid   <= 1'b0;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_wptr   <= r_wptr + PW'(w_push);
            r_rptr   <= r_rptr + PW'(w_pop);
            r_wif    <= w_pop;
            if (w_pop) begin
                r_wif_addr <= r_fa[w_ridx];
            end
            r_rvalid <= w_rd_acc | w_fwd;
            r_fwd    <= w_fwd;
            if (w_fwd) begin
                r_fwd_data <= w_fwd_data;
            end
        end
    end

    // Sticky write error: first failure kept; a coincident new error beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_werr      <= 1'b0;
            r_werr_addr <= '0;
        end else if (r_wif && err_i && (!r_werr || werr_clr)) begin
            r_werr      <= 1'b1;
            r_werr_addr <= r_wif_addr;
        end else if (werr_clr) begin
            r_werr      <= 1'b0;
            r_werr_addr <= '0;
        end
    end

endmodule

// File: tb/tb_cm7sys_tcmreq.sv
// Directed self-checking bench for cm7sys_tcmreq (default DEPTH=2, AW=13, DW=32).
module tb_cm7sys_tcmreq;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_cs;
    logic [3:0]  c_we;
    logic [12:0] c_addr;
    logic [31:0] c_wd;
    logic        c_stall;
    logic [31:0] c_rd;
    logic        c_rvalid;
    logic        c_rerr;
    logic [12:0] addr_o;
    logic [31:0] wd_o;
    logic        cs_o;
    logic [3:0]  we_o;
    logic [31:0] rd_i;
    logic        wait_i;
    logic        err_i;
    logic        werr;
    logic [12:0] werr_addr;
    logic        werr_clr;

    int errors = 0;
    int checks = 0;

    cm7sys_tcmreq dut (
        .clk(clk), .reset(reset),
        .c_cs(c_cs), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
        .c_stall(c_stall), .c_rd(c_rd), .c_rvalid(c_rvalid), .c_rerr(c_rerr),
        .addr_o(addr_o), .wd_o(wd_o), .cs_o(cs_o), .we_o(we_o),
        .rd_i(rd_i), .wait_i(wait_i), .err_i(err_i),
        .werr(werr), .werr_addr(werr_addr), .werr_clr(werr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic cs, input logic [3:0] we, input logic [12:0] a, input logic [31:0] d);
        c_cs = cs; c_we = we; c_addr = a; c_wd = d;
        #1;
    endtask

    initial begin
        reset = 1'b1; c_cs = 0; c_we = 0; c_addr = 0; c_wd = 0;
        rd_i = 0; wait_i = 0; err_i = 0; werr_clr = 0;
        repeat (2) tick();
        #1;
        // reset state
        chk("rst_stall", 64'(c_stall), 0);
        chk("rst_rsp", {c_rvalid, c_rerr, c_rd}, 0);
        chk("rst_tcm", {cs_o, we_o, addr_o, wd_o}, 0);
        chk("rst_werr", {werr, werr_addr}, 0);
        reset = 1'b0;
        tick();

        // write posting with a 4-cycle wait
        req(1, 4'hF, 13'h010, 32'hA0);
        chk("wp_a_stall", 64'(c_stall), 0);
        chk("wp_a_cs", 64'(cs_o), 0);
        tick();
        wait_i = 1;
        req(1, 4'h3, 13'h011, 32'hB1);
        chk("wp_b_stall", 64'(c_stall), 0);
        chk("wp_b_tcm", {cs_o, addr_o, we_o}, {1'b1, 13'h010, 4'hF});
        tick();
        req(1, 4'hC, 13'h012, 32'hC2);
        for (int i = 0; i < 3; i++) begin
            chk("wp_full_stall", 64'(c_stall), 1);
            chk("wp_hold", {cs_o, addr_o, wd_o}, {1'b1, 13'h010, 32'hA0});
            tick();
        end
        wait_i = 0;
        #1;
        chk("wp_nobypass", 64'(c_stall), 1);
        tick();
        chk("wp_g_stall", 64'(c_stall), 0);
        chk("wp_g_tcm", {cs_o, addr_o, we_o, wd_o}, {1'b1, 13'h011, 4'h3, 32'hB1});
        tick();
        req(0, 0, 0, 0);
        chk("wp_h_tcm", {cs_o, addr_o, we_o, wd_o}, {1'b1, 13'h012, 4'hC, 32'hC2});
        tick();
        chk("wp_idle", {cs_o, addr_o, we_o, wd_o}, 0);

        // read ordering behind a posted write
        req(1, 4'hF, 13'h020, 32'hDEADBEEF);
        chk("ro_wr_stall", 64'(c_stall), 0);
        tick();
        req(1, 4'h0, 13'h020, 0);
        chk("ro_fifo_stall", 64'(c_stall), 1);
        chk("ro_head", {cs_o, addr_o, we_o}, {1'b1, 13'h020, 4'hF});
        tick();
        chk("ro_wif_stall", 64'(c_stall), 1);
        chk("ro_wif_cs", 64'(cs_o), 0);
        tick();
        chk("ro_go_stall", 64'(c_stall), 0);
        chk("ro_go_tcm", {cs_o, addr_o, we_o}, {1'b1, 13'h020, 4'h0});
        tick();
        req(0, 0, 0, 0);
        rd_i = 32'hDEADBEEF;
        #1;
        chk("ro_rsp", {c_rvalid, c_rerr, c_rd}, {1'b1, 1'b0, 32'hDEADBEEF});
        tick();
        rd_i = 0;
        #1;
        chk("ro_rvalid_low", 64'(c_rvalid), 0);

        // back-to-back reads
        req(1, 0, 13'h100, 0);
        chk("bb_r1", {c_stall, cs_o, addr_o}, {1'b0, 1'b1, 13'h100});
        tick();
        req(1, 0, 13'h101, 0);
        rd_i = 32'h1111; #1;
        chk("bb_r2", {c_stall, cs_o, addr_o}, {1'b0, 1'b1, 13'h101});
        chk("bb_d1", {c_rvalid, c_rd}, {1'b1, 32'h1111});
        tick();
        req(0, 0, 0, 0);
        rd_i = 32'h2222; #1;
        chk("bb_d2", {c_rvalid, c_rd}, {1'b1, 32'h2222});
        tick();
        rd_i = 0;

        // read held by TCM wait
        wait_i = 1;
        req(1, 0, 13'h060, 0);
        chk("rw_stall", {c_stall, cs_o, we_o}, {1'b1, 1'b1, 4'h0});
        tick();
        wait_i = 0; #1;
        chk("rw_go", 64'(c_stall), 0);
        tick();
        req(0, 0, 0, 0);
        rd_i = 32'h6060; #1;
        chk("rw_rsp", {c_rvalid, c_rd}, {1'b1, 32'h6060});
        tick();
        rd_i = 0;

        // read error
        req(1, 0, 13'h050, 0);
        tick();
        req(0, 0, 0, 0);
        err_i = 1; #1;
        chk("re_rsp", {c_rvalid, c_rerr}, {1'b1, 1'b1});
        tick();
        err_i = 0; #1;
        chk("re_werr", {werr, werr_addr}, 0);

        // write errors: first kept, clear loses to a coincident error
        req(1, 4'hF, 13'h040, 32'h40);
        tick();
        req(1, 4'hF, 13'h041, 32'h41);
        tick();
        req(0, 0, 0, 0);
        err_i = 1;
        tick();
        chk("we_first", {werr, werr_addr}, {1'b1, 13'h040});
        tick();
        err_i = 0;
        req(1, 4'hF, 13'h042, 32'h42);
        chk("we_keep", {werr, werr_addr}, {1'b1, 13'h040});
        tick();
        req(0, 0, 0, 0);
        tick();
        err_i = 1; werr_clr = 1;
        tick();
        err_i = 0; werr_clr = 0; #1;
        chk("we_clr_err", {werr, werr_addr}, {1'b1, 13'h042});
        werr_clr = 1;
        tick();
        werr_clr = 0; #1;
        chk("we_cleared", {werr, werr_addr}, 0);

        // read after a full-word posted write (forwarded when enabled)
        wait_i = 1;
        req(1, 4'hF, 13'h030, 32'h12345678);
        tick();
        req(1, 4'h0, 13'h030, 0);
`ifdef CM7TCMREQ_RAWFWD_EN
        chk("fw_stall", 64'(c_stall), 0);
`else
        chk("fw_stall", 64'(c_stall), 1);
`endif
        chk("fw_head", {cs_o, addr_o, we_o}, {1'b1, 13'h030, 4'hF});
        tick();
        req(1, 4'h3, 13'h031, 32'h5555AAAA);
`ifdef CM7TCMREQ_RAWFWD_EN
        chk("fw_rsp", {c_rvalid, c_rerr, c_rd}, {1'b1, 1'b0, 32'h12345678});
`else
        chk("fw_rsp", {c_rvalid, c_rerr, c_rd}, 0);
`endif
        chk("fw_noread", {cs_o, addr_o, we_o}, {1'b1, 13'h030, 4'hF});
        tick();
        req(1, 4'h0, 13'h031, 0);
        chk("fw_partial_stall", 64'(c_stall), 1);
        tick();
        req(0, 0, 0, 0);
        wait_i = 0;
        repeat (4) tick();
        chk("fw_drained", 64'(cs_o), 0);

        // reset mid-drain discards queued writes
        wait_i = 1;
        req(1, 4'hF, 13'h070, 32'h70);
        tick();
        req(1, 4'hF, 13'h071, 32'h71);
        tick();
        req(0, 0, 0, 0);
        chk("rs_busy", {cs_o, addr_o}, {1'b1, 13'h070});
        reset = 1; #1;
        chk("rs_async", {cs_o, addr_o, we_o, wd_o}, 0);
        tick();
        reset = 0; wait_i = 0; #1;
        chk("rs_empty", {cs_o, c_stall}, 0);
        tick();
        chk("rs_nostale", {cs_o, addr_o}, 0);
        tick();
        chk("rs_nostale2", 64'(cs_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cm7sys_tcmreq.md
# cm7sys_tcmreq

Request-side posting stage between the CM7 TCM master port and the TCM macro wrapper. Buffers core writes in a small FIFO so the core does not stall on TCM wait states, enforces in-order drain before reads, returns read data, and captures write-error status. Sits directly upstream of the TCM wrapper and drives its `addr`/`wd`/`cs`/`we` inputs while consuming its `rd`/`wait`/`err` outputs.

## Interface
- `AW`, 13: word address width.
- `DW`, 32: data width, multiple of 8.
- `DEPTH`, 2: write FIFO entries, power of two, 2..4.
- `clk` in 1: single clock, all logic.
- `reset` in 1: asynchronous, active-high reset.
- `c_cs` in 1: core request valid.
- `c_we` in DW/8: byte write enables; all-zero means read.
- `c_addr` in AW: core word address.
- `c_wd` in DW: core write data.
- `c_stall` out 1: core must hold its request this cycle.
- `c_rd` out DW: read data.
- `c_rvalid` out 1: `c_rd`/`c_rerr` valid.
- `c_rerr` out 1: read error, qualified by `c_rvalid`.
- `addr_o` out AW, `wd_o` out DW, `cs_o` out 1, `we_o` out DW/8: TCM request.
- `rd_i` in DW, `wait_i` in 1, `err_i` in 1: TCM response.
- `werr` out 1: sticky write-error flag.
- `werr_addr` out AW: address of first failing write.
- `werr_clr` in 1: clears `werr`, `werr_addr`.

## Operation
- Core accept: `c_cs & ~c_stall`.
- Write accept: pushes {addr, we, wd} into FIFO. `c_stall` for a write = FIFO full; no push/pop bypass when full.
- Read accept: only when FIFO empty and no write in flight. Driven combinationally onto TCM: `cs_o=c_cs`, `we_o=0`. `c_stall` for a read = FIFO non-empty | write in flight | `wait_i`.
- TCM port owner: FIFO head when non-empty; otherwise core read; otherwise idle (`cs_o=0`, `addr_o`/`wd_o`/`we_o` = 0).
- TCM accept: `cs_o & ~wait_i`; pops FIFO for writes. While `wait_i` is high, the request is held stable.
- Read response: `c_rvalid=1` the cycle after TCM accept of a read. `c_rd=rd_i`, `c_rerr=err_i`.
- Write response: `err_i` is sampled the cycle after TCM accept of a write (the write-in-flight cycle). On error with `werr=0`: `werr<=1`, `werr_addr<=` that address. Later errors do not overwrite.
- `werr_clr` and a new error in the same cycle: the error wins (flag set, address captured).
- FIFO pointers are `$clog2(DEPTH)+1` bits wide and wrap naturally. Full = MSB differ, rest equal.

## Timing
- Reset values: `c_stall=0`, `c_rvalid=0`, `c_rerr=0`, `c_rd=0`, `cs_o=0`, `we_o=0`, `addr_o=0`, `wd_o=0`, `werr=0`, `werr_addr=0`. FIFO is empty.
- Reset asserted mid-operation discards buffered writes. Outputs go to reset values asynchronously.
- Write latency: core accept in cycle N gives `cs_o` in N+1 at the earliest.
- Read latency on an empty FIFO with `wait_i=0`: data returns in N+1.
- Back-to-back reads sustain 1 per cycle.
- Back-to-back writes sustain 1 per cycle when `wait_i=0`.

## Configuration
- `CM7TCMREQ_RAWFWD_EN` defined: a read whose address matches a FIFO entry with `we` all-ones is forwarded without draining.
  - Read is accepted even if the FIFO is non-empty. `c_stall` for the read is 0.
  - Data comes from the newest matching entry. `c_rvalid=1` the next cycle with `c_rerr=0`.
  - No TCM read is issued.
  - A partial-byte match still stalls until the FIFO drains.
- Undefined: every read waits for an empty FIFO.

## Test plan
- Reset: assert `reset` mid-drain with 2 entries queued → `cs_o=0` immediately. After release, FIFO is empty and no stale write reaches TCM.
- Write posting: 3 writes to 0x010/0x011/0x012 with `wait_i=1` for 4 cycles, `DEPTH=2` → third write stalls until the first pop. TCM sees the three writes in order with correct `we`.
- Read ordering: write 0x020=0xDEADBEEF, then read 0x020 immediately, macro off → read stalls until the write is accepted plus its in-flight cycle. `c_rd=0xDEADBEEF`.
- Forwarding, macro on: full-word write 0x030=0x12345678 held by `wait_i=1`, read 0x030 → `c_rvalid` next cycle with 0x12345678 and no TCM read. A `we=4'b0011` write to 0x031 followed by a read of 0x031 stalls.
- Write error: `err_i=1` on write to 0x040, then on write to 0x041 → `werr=1`, `werr_addr=0x040`. `werr_clr` coinciding with a new error on 0x042 gives `werr=1`, `werr_addr=0x042`.
- Read error: `err_i=1` after read of 0x050 → `c_rvalid=1`, `c_rerr=1`, `werr` unchanged.
